// File: rtl/pipe_perf_monitor_pkg.sv
// Shared types for the pipeline performance monitor: counter select codes,
// FSM states and the default counter width.
package perf_pkg;

  localparam int PERF_CNT_W = 32;

  typedef enum logic [1:0] {
    CYC    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    RETIRE = 2'd3
  } cnt_sel_e;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_perf_monitor_if.sv
// Readout request/response port of the performance monitor; the requester
// uses the master modport, the monitor the slave modport.
interface pipe_perf_monitor_if #(
  parameter int CNT_W = 32
) ();

  logic             rd_req_i;
  logic [1:0]       rd_sel_i;
  logic             rd_valid_o;
  logic [CNT_W-1:0] rd_data_o;

  modport master (
    output rd_req_i,
    output rd_sel_i,
    input  rd_valid_o,
    input  rd_data_o
  );

  modport slave (
    input  rd_req_i,
    input  rd_sel_i,
    output rd_valid_o,
    output rd_data_o
  );

endinterface

// File: rtl/pipe_perf_monitor_counter.sv
// One event counter with sticky overflow; wraps by default, saturates at
// all-ones when PERF_SAT_EN is defined.
module perf_event_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         hold,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         ovf
);

  localparam logic [W-1:0] ONE = W'(1);

  logic at_max;
  assign at_max = (value == {W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (inc && !hold) begin
      if (at_max) begin
        ovf <= 1'b1;
`ifdef PERF_SAT_EN
        value <= value;
`else
        value <= '0;
`endif
      end else begin
        value <= value + ONE;
      end
    end
  end

endmodule

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: cycle/stall/flush/retire counters, cycle-limit
// halt and a one-cycle-latency readout port. Saturating counters via PERF_SAT_EN.
module pipe_perf_monitor
  import perf_pkg::*;
#(
  parameter int CNT_W = PERF_CNT_W
) (
  input  logic                clk_i,
  input  logic                start_i,
  input  logic                stall_i,
  input  logic                branch_i,
  input  logic                flush_i,
  input  logic                retire_i,
  input  logic [CNT_W-1:0]    limit_i,
  input  logic                clear_i,
  pipe_perf_monitor_if.slave  rd,
  output logic                done_o,
  output logic [3:0]          ovf_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state, state_nxt;
  logic             hold;
  logic             limit_hit;
  logic [CNT_W-1:0] cyc_val, stall_val, flush_val, ret_val;
  logic [CNT_W-1:0] rd_mux;
  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q;

  assign hold = (state == DONE);

  // A saturated cycle counter never advances, so cyc_val + 1 wrapping to 0
  // can never match a nonzero limit in either build.
  assign limit_hit = (limit_i != '0) && ((cyc_val + ONE) == limit_i);

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear_i) begin
      state_nxt = RUN;
    end else if (state == RUN && limit_hit) begin
      state_nxt = DONE;
    end
  end

  assign done_o = (state == DONE);

  perf_event_counter #(.W(CNT_W)) u_cyc (
    .clk(clk_i), .rst_n(start_i), .inc(1'b1), .hold(hold), .clr(clear_i),
    .value(cyc_val), .ovf(ovf_o[CYC])
  );

  perf_event_counter #(.W(CNT_W)) u_stall (
    .clk(clk_i), .rst_n(start_i), .inc(stall_i & ~branch_i), .hold(hold),
    .clr(clear_i), .value(stall_val), .ovf(ovf_o[STALL])
  );

  perf_event_counter #(.W(CNT_W)) u_flush (
    .clk(clk_i), .rst_n(start_i), .inc(flush_i), .hold(hold), .clr(clear_i),
    .value(flush_val), .ovf(ovf_o[FLUSH])
  );

  perf_event_counter #(.W(CNT_W)) u_retire (
    .clk(clk_i), .rst_n(start_i), .inc(retire_i), .hold(hold), .clr(clear_i),
    .value(ret_val), .ovf(ovf_o[RETIRE])
  );

  always_comb begin
    rd_mux = cyc_val;
    case (cnt_sel_e'(rd.rd_sel_i))
      CYC:     rd_mux = cyc_val;
      STALL:   rd_mux = stall_val;
      FLUSH:   rd_mux = flush_val;
      RETIRE:  rd_mux = ret_val;
      default: rd_mux = cyc_val;
    endcase
  end

  // Readout captures pre-update values, so a request alongside clear_i
  // still returns the count being cleared.
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd.rd_req_i;
      if (rd.rd_req_i) begin
        rd_data_q <= rd_mux;
      end
    end
  end

  assign rd.rd_valid_o = rd_valid_q;
  assign rd.rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Scoreboard bench for pipe_perf_monitor: a 32-bit instance for function and
// a 4-bit instance for wrap/saturation.
module tb_pipe_perf_monitor;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        start, stall, branch, flush, retire, clear;
  logic [31:0] limit;
  logic        done;
  logic [3:0]  ovf;

  logic        s_start, s_clear;
  logic [3:0]  s_limit;
  logic        s_done;
  logic [3:0]  s_ovf;

  pipe_perf_monitor_if #(.CNT_W(32)) rdm ();
  pipe_perf_monitor_if #(.CNT_W(4))  rds ();

  pipe_perf_monitor #(.CNT_W(32)) dut (
    .clk_i(clk), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush), .retire_i(retire), .limit_i(limit), .clear_i(clear),
    .rd(rdm.slave), .done_o(done), .ovf_o(ovf)
  );

  pipe_perf_monitor #(.CNT_W(4)) dut_s (
    .clk_i(clk), .start_i(s_start), .stall_i(1'b0), .branch_i(1'b0),
    .flush_i(1'b0), .retire_i(1'b0), .limit_i(s_limit), .clear_i(s_clear),
    .rd(rds.slave), .done_o(s_done), .ovf_o(s_ovf)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_m[$];
  int          tag_m[$];
  logic [3:0]  exp_s[$];
  int          tag_s[$];
  int          n_req = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_m(input logic [1:0] sel, input logic [31:0] exp);
    rdm.rd_req_i = 1'b1;
    rdm.rd_sel_i = sel;
    exp_m.push_back(exp);
    tag_m.push_back(n_req++);
    tick();
    rdm.rd_req_i = 1'b0;
  endtask

  // Scoreboard monitors: pop one expectation per presented response.
  initial begin
    forever begin
      @(negedge clk);
      if (rdm.rd_valid_o === 1'b1) begin
        if (exp_m.size() == 0) begin
          check("rd_main_unexpected", 32'd1, 32'd0);
        end else begin
          automatic logic [31:0] e = exp_m.pop_front();
          automatic int t = tag_m.pop_front();
          check($sformatf("rd_main#%0d", t), rdm.rd_data_o, e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rds.rd_valid_o === 1'b1) begin
        if (exp_s.size() == 0) begin
          check("rd_small_unexpected", 32'd1, 32'd0);
        end else begin
          automatic logic [3:0] e = exp_s.pop_front();
          automatic int t = tag_s.pop_front();
          check($sformatf("rd_small#%0d", t), {28'd0, rds.rd_data_o}, {28'd0, e});
        end
      end
    end
  end

  initial begin
    start = 1'b0; stall = 1'b0; branch = 1'b0; flush = 1'b0; retire = 1'b0;
    clear = 1'b0; limit = 32'd0;
    rdm.rd_req_i = 1'b0; rdm.rd_sel_i = 2'd0;
    s_start = 1'b0; s_clear = 1'b0; s_limit = 4'd0;
    rds.rd_req_i = 1'b0; rds.rd_sel_i = 2'd0;

    tick(); tick();
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_ovf", {28'd0, ovf}, 32'd0);
    check("reset_rd_valid", {31'd0, rdm.rd_valid_o}, 32'd0);
    check("reset_rd_data", rdm.rd_data_o, 32'd0);

    // 10 counted edges: stall every cycle, flush on the first 3.
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stall = 1'b1;
      flush = (i < 3);
      tick();
    end
    stall = 1'b0; flush = 1'b0;
    req_m(2'd0, 32'd10);
    req_m(2'd1, 32'd10);
    req_m(2'd2, 32'd3);
    req_m(2'd3, 32'd0);

    // Branch-qualified stalls do not count; retires do.
    stall = 1'b1; branch = 1'b1; retire = 1'b1;
    repeat (5) tick();
    stall = 1'b0; branch = 1'b0; retire = 1'b0;
    req_m(2'd1, 32'd10);
    req_m(2'd0, 32'd20);
    req_m(2'd3, 32'd5);

    // All events in a single cycle.
    stall = 1'b1; flush = 1'b1; retire = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0; retire = 1'b0;
    req_m(2'd2, 32'd4);
    req_m(2'd3, 32'd6);
    req_m(2'd1, 32'd11);
    check("ovf_main_clean", {28'd0, ovf}, 32'd0);

    // Cycle limit of 64 from reset.
    start = 1'b0; limit = 32'd64;
    tick();
    start = 1'b1;
    repeat (63) tick();
    check("done_before_limit", {31'd0, done}, 32'd0);
    tick();
    check("done_at_limit", {31'd0, done}, 32'd1);
    stall = 1'b1; flush = 1'b1; retire = 1'b1;
    repeat (5) tick();
    stall = 1'b0; flush = 1'b0; retire = 1'b0;
    req_m(2'd1, 32'd0);
    req_m(2'd2, 32'd0);
    req_m(2'd3, 32'd0);
    req_m(2'd0, 32'd64);
    check("done_held", {31'd0, done}, 32'd1);

    // Clear in DONE with a simultaneous read returns the pre-clear value.
    clear = 1'b1;
    req_m(2'd0, 32'd64);
    clear = 1'b0;
    check("done_after_clear", {31'd0, done}, 32'd0);
    repeat (3) tick();
    req_m(2'd0, 32'd3);
    req_m(2'd2, 32'd0);

    // Limit below the current count: no match.
    limit = 32'd2;
    repeat (4) tick();
    check("limit_below_no_done", {31'd0, done}, 32'd0);
    limit = 32'd0;

    // Reset mid-run with a read pending.
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    rdm.rd_req_i = 1'b1; rdm.rd_sel_i = 2'd0;
    start = 1'b0;
    tick();
    rdm.rd_req_i = 1'b0;
    start = 1'b1;
    check("midreset_rd_valid", {31'd0, rdm.rd_valid_o}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_rd_data", rdm.rd_data_o, 32'd0);
    req_m(2'd1, 32'd0);
    req_m(2'd0, 32'd1);

    // 4-bit counters across the wrap point.
    s_start = 1'b1;
    repeat (15) tick();
    check("small_ovf_pre", {28'd0, s_ovf}, 32'd0);
    tick();
    check("small_ovf_set", {28'd0, s_ovf}, 32'd1);
    tick();
    rds.rd_req_i = 1'b1; rds.rd_sel_i = 2'd0;
`ifdef PERF_SAT_EN
    exp_s.push_back(4'd15);
`else
    exp_s.push_back(4'd1);
`endif
    tag_s.push_back(0);
    tick();
    rds.rd_req_i = 1'b0;
    check("small_done", {31'd0, s_done}, 32'd0);

    repeat (4) tick();
    check("main_queue_drained", exp_m.size(), 32'd0);
    check("small_queue_drained", exp_s.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=1 want=0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_perf_monitor.md
# pipe_perf_monitor

Synthesizable performance monitor that consumes the pipeline's hazard/flush/retire strobes and produces cycle, stall, flush and retired-instruction counts, plus a cycle-limit halt. It sits beside the CPU top, downstream of the Hazard_Detection_Unit, Control and writeback stage. It replaces bench-side event counting with in-silicon counters that the bench and the on-board debug path read through one request/response port.

## Interface
- CNT_W, 32, width of every counter, of limit_i and of rd_data_o
- clk_i  in  1  clock; all state updates on rising edge
- start_i  in  1  synchronous active-low reset; low at a rising edge clears all state
- stall_i  in  1  hazard unit stall strobe
- branch_i  in  1  Control branch indication; qualifies stall_i
- flush_i  in  1  Control flush strobe
- retire_i  in  1  one instruction leaves WB this cycle
- limit_i  in  CNT_W  cycle limit; 0 = unlimited; sampled every cycle
- clear_i  in  1  zero all counters and return to RUN
- rd_req_i  in  1  readout request
- rd_sel_i  in  2  0 cycles, 1 stalls, 2 flushes, 3 retired
- rd_valid_o  out  1  readout data valid
- rd_data_o  out  CNT_W  readout value
- done_o  out  1  cycle limit reached; counting frozen
- ovf_o  out  4  sticky per-counter overflow, bit index = rd_sel encoding

## Operation
- FSM states: RUN, DONE. Reset state RUN.
- RUN -> DONE when the cycle counter increments to a value equal to a nonzero limit_i.
- DONE -> RUN only on clear_i. There is no other exit.
- In RUN, each edge applies these increments:
  - cycles +1 unconditionally
  - stalls +1 if stall_i && !branch_i
  - flushes +1 if flush_i
  - retired +1 if retire_i
- All four events are independent. Any combination in one cycle increments each qualifying counter once.
- In DONE, all counters hold and event inputs are ignored.
- clear_i zeroes all four counters and clears ovf_o. The cycle in which clear_i is high is not counted.
- clear_i has priority over both limit match and events.
- limit_i changed below the current cycle count: no match until wrap. In PERF_SAT_EN builds there is no match at all.
- Readout is pipelined. A rd_req_i sampled at edge N returns rd_valid_o=1 and rd_data_o = the selected counter's value before edge N's update, after edge N.
- Back-to-back requests are allowed every cycle. Readout is legal in RUN and DONE.
- rd_req_i together with clear_i returns the pre-clear value.
- rd_data_o holds its last value when rd_valid_o=0.

## Timing
- Reset (start_i low at an edge) sets:
  - all counters 0
  - state RUN
  - done_o 0
  - ovf_o 0
  - rd_valid_o 0
  - rd_data_o 0
- Reset overrides every other input, including mid-readout and in DONE.
- First counted cycle is the first edge with start_i high.
- done_o is registered. It rises at the same edge where cycles becomes equal to limit_i.
- Readout latency is exactly 1 cycle. rd_valid_o stays high for exactly 1 cycle per request.
- No combinational path from any input to any output.

## Configuration
- PERF_SAT_EN defined: each counter saturates at all-ones and holds. ovf_o bit sets at the edge where the counter would have wrapped.
- PERF_SAT_EN undefined: counters wrap to 0 at all-ones+1. ovf_o bit sets at that same edge.
- In both builds ovf_o is sticky until reset or clear_i.

## Structure
- Package perf_pkg holds:
  - typedef of the 2-bit counter-select enum (CYC, STALL, FLUSH, RETIRE)
  - default CNT_W
  - state enum (RUN, DONE)
- Sub-module perf_event_counter: one CNT_W counter with inc, hold and clr inputs, value output and sticky ovf output. Saturate/wrap is selected by PERF_SAT_EN. The top instantiates four of them.
- The top holds the FSM, event qualification and readout register.

## Test plan
- Reset, then 10 cycles with stall_i=1, branch_i=0, flush_i=1 on 3 of them -> read sel 0,1,2 returns 10, 10, 3 (pre-edge values per request cycle).
- stall_i=1 with branch_i=1 for 5 cycles -> stall count unchanged, cycle count +5.
- limit_i=64 from reset -> done_o rises when cycles=64. Further events leave all counts frozen. A readout in DONE returns cycles=64.
- clear_i in DONE together with rd_req_i sel 0 -> rd_data_o=64. Next cycle counts are 0, done_o=0, and counting resumes.
- CNT_W=4, run 17 cycles:
  - PERF_SAT_EN: cycles=15, ovf_o[0]=1
  - without: cycles=1, ovf_o[0]=1
- start_i driven low for one edge mid-run with rd_req_i high -> all counters 0, rd_valid_o=0 and done_o=0 next cycle.
